hazard_ctrl: RTL

Pipeline hazard controller for the five-stage MIPS core; it sits beside the instruction decoder. It keeps a shadow record of destination registers in flight through EX, MEM and WB, and from that record it produces load-use stalls, branch and jump flushes, and EX-stage operand-forwarding selects. It also sequences BREAK, draining the pipeline and then halting.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and shadow-entry type for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'b00,
        HZ_DRAIN = 2'b01,
        HZ_HALT  = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regw;
    } shadow_ent_t;

    // An entry can feed a source only if it really writes a non-zero register.
    function automatic logic fwd_hit(input shadow_ent_t ent, input logic [4:0] src);
        return ent.valid & ent.regw & (ent.dst != 5'd0) & (ent.dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder-side handshake bundle between the core and the hazard controller.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_regw;
    logic       id_memr;
    logic       id_jump;
    logic       id_break;
    logic       ex_br_taken;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regw, id_memr, id_jump, id_break, ex_br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regw, id_memr, id_jump, id_break, ex_br_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source register; MEM beats WB.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]  src,
    input  shadow_ent_t mem_ent,
    input  shadow_ent_t wb_ent,
    output logic [1:0]  sel
);

    // Youngest matching producer wins.
    always_comb begin
        if (fwd_hit(mem_ent, src)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(wb_ent, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB record, stalls, flushes,
// forwarding selects and the BREAK drain/halt sequencer.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_e         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ex_valid_r;
    logic [4:0]        ex_rs_r;
    logic [4:0]        ex_rt_r;
    logic [4:0]        ex_dst_r;
    logic              ex_regw_r;
    logic              ex_memr_r;
    shadow_ent_t       mem_r;
    shadow_ent_t       wb_r;

    logic load_use_s;
    logic brk_acc_s;
    logic pc_en_s;
    logic ifid_en_s;
    logic flush_s;
    logic bubble_s;
    logic halt_s;

    assign load_use_s = ex_valid_r & ex_memr_r & (ex_dst_r != 5'd0) &
                        ((hz.id_uses_rs & (hz.id_rs == ex_dst_r)) |
                         (hz.id_uses_rt & (hz.id_rt == ex_dst_r)));

    // Control outputs: branch > load-use > jump > BREAK while running.
    always_comb begin
        pc_en_s   = 1'b1;
        ifid_en_s = 1'b1;
        flush_s   = 1'b0;
        bubble_s  = 1'b0;
        halt_s    = 1'b0;
        brk_acc_s = 1'b0;
        case (state_r)
            HZ_RUN: begin
                if (hz.ex_br_taken) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                end else if (load_use_s) begin
                    pc_en_s   = 1'b0;
                    ifid_en_s = 1'b0;
                    bubble_s  = 1'b1;
                end else if (hz.id_valid & hz.id_jump) begin
                    flush_s = 1'b1;
                end else if (hz.id_valid & hz.id_break) begin
                    brk_acc_s = 1'b1;
                end else begin
                    brk_acc_s = 1'b0;
                end
            end
            HZ_DRAIN: begin
                pc_en_s   = 1'b0;
                ifid_en_s = 1'b0;
                bubble_s  = 1'b1;
            end
            HZ_HALT: begin
                halt_s    = 1'b1;
                pc_en_s   = 1'b0;
                ifid_en_s = 1'b0;
                bubble_s  = 1'b1;
            end
            default: begin
                halt_s    = 1'b1;
                pc_en_s   = 1'b0;
                ifid_en_s = 1'b0;
                bubble_s  = 1'b1;
            end
        endcase
    end

    // BREAK sequencer; an undefined encoding parks in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HZ_RUN;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                HZ_RUN: begin
                    if (brk_acc_s) begin
                        state_r <= HZ_DRAIN;
                        cnt_r   <= CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_r <= HZ_RUN;
                    end
                end
                HZ_DRAIN: begin
                    if (cnt_r == '0) begin
                        state_r <= HZ_HALT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                HZ_HALT: state_r <= HZ_HALT;
                default: state_r <= HZ_HALT;
            endcase
        end
    end

    // Shadow pipeline; a bubble is an all-zero NOP so it never matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_rs_r    <= 5'd0;
            ex_rt_r    <= 5'd0;
            ex_dst_r   <= 5'd0;
            ex_regw_r  <= 1'b0;
            ex_memr_r  <= 1'b0;
            mem_r      <= '0;
            wb_r       <= '0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= '{valid: ex_valid_r, dst: ex_dst_r, regw: ex_regw_r};
            if (bubble_s) begin
                ex_valid_r <= 1'b0;
                ex_rs_r    <= 5'd0;
                ex_rt_r    <= 5'd0;
                ex_dst_r   <= 5'd0;
                ex_regw_r  <= 1'b0;
                ex_memr_r  <= 1'b0;
            end else begin
                ex_valid_r <= hz.id_valid;
                ex_rs_r    <= hz.id_rs;
                ex_rt_r    <= hz.id_rt;
                ex_dst_r   <= hz.id_dst;
                ex_regw_r  <= hz.id_regw;
                ex_memr_r  <= hz.id_memr;
            end
        end
    end

    hazard_fwd_sel u_fwd_a (
        .src     (ex_rs_r),
        .mem_ent (mem_r),
        .wb_ent  (wb_r),
        .sel     (hz.fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .src     (ex_rt_r),
        .mem_ent (mem_r),
        .wb_ent  (wb_r),
        .sel     (hz.fwd_b)
    );

    assign hz.pc_en       = pc_en_s;
    assign hz.ifid_en     = ifid_en_s;
    assign hz.ifid_flush  = flush_s;
    assign hz.idex_bubble = bubble_s;
    assign hz.halt        = halt_s;

endmodule
